// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the naive_soc memory path: the arbiter
// grant encoding, the last-winner encoding and the bus width defaults that
// wb_ram also uses.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_INST = 2'b01,
    GNT_DATA = 2'b10
  } gnt_t;

  // Encoding of the last-winner bit used for round-robin tie breaking.
  localparam logic LAST_INST = 1'b0;
  localparam logic LAST_DATA = 1'b1;

  // Maps a grant to the last-winner bit it should leave behind.
  function automatic logic last_of(input gnt_t g);
    return (g == GNT_DATA) ? LAST_DATA : LAST_INST;
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone classic bus bundle. The master modport is the side that issues
// cycles; the slave modport is the side that answers them.
interface wb_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  localparam int SELW = DW / 8;

  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [SELW-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [DW-1:0]   rdata;
  logic            ack;

  modport master (
    output addr, wdata, sel, we, cyc, stb,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, sel, we, cyc, stb,
    output rdata, ack
  );
endinterface

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
// Optional feature: define WB_ARB_RR_EN for round-robin tie breaking;
// otherwise ties go to the data master (fixed priority) and `last` is ignored.
module wb_arb_pick
  import wb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last,
  output gnt_t winner
);

  gnt_t tie_s;

`ifdef WB_ARB_RR_EN
  // The master that did not win last time takes the tie.
  assign tie_s = (last == LAST_DATA) ? GNT_INST : GNT_DATA;
`else
  logic unused_last_s;
  assign unused_last_s = last;
  assign tie_s         = GNT_DATA;
`endif

  // Single requester wins outright; two requesters defer to the tie rule.
  always_comb begin
    winner = GNT_NONE;
    if (i_req && d_req) begin
      winner = tie_s;
    end else if (d_req) begin
      winner = GNT_DATA;
    end else if (i_req) begin
      winner = GNT_INST;
    end else begin
      winner = GNT_NONE;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter (ibus fetch + dbus
// load/store -> wb_ram). Whole cycles are granted: the owner keeps the slave
// until it drops cyc, the other master simply sees no ack.
// Optional feature macro: WB_ARB_RR_EN (round-robin ties, see wb_arb_pick).
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW,
  parameter int SELW = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  wb_arbiter2_if.slave  i_bus,
  wb_arbiter2_if.slave  d_bus,
  wb_arbiter2_if.master s_bus
);

  gnt_t gnt_q, gnt_d, winner_s;
  logic last_q, last_d;

  wb_arb_pick u_pick (
    .i_req  (i_bus.cyc),
    .d_req  (d_bus.cyc),
    .last   (last_q),
    .winner (winner_s)
  );

  // Next grant: hold while the owner keeps cyc, otherwise hand straight to
  // whoever is requesting (the owner's cyc is already low, so the picker
  // only sees the other master or nothing).
  always_comb begin
    gnt_d  = gnt_q;
    last_d = last_q;
    case (gnt_q)
      GNT_INST: begin
        if (i_bus.cyc) gnt_d = GNT_INST;
        else           gnt_d = winner_s;
      end
      GNT_DATA: begin
        if (d_bus.cyc) gnt_d = GNT_DATA;
        else           gnt_d = winner_s;
      end
      GNT_NONE: gnt_d = winner_s;
      default:  gnt_d = GNT_NONE;
    endcase
    if (gnt_d != GNT_NONE) last_d = last_of(gnt_d);
    else                   last_d = last_q;
  end

  // Grant and last-winner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q  <= GNT_NONE;
      last_q <= LAST_INST;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  // Slave-side mux: pass the owner's request through, idle bus otherwise.
  always_comb begin
    s_bus.addr  = {AW{1'b0}};
    s_bus.wdata = {DW{1'b0}};
    s_bus.sel   = {SELW{1'b0}};
    s_bus.we    = 1'b0;
    s_bus.cyc   = 1'b0;
    s_bus.stb   = 1'b0;
    case (gnt_q)
      GNT_INST: begin
        s_bus.addr  = i_bus.addr;
        s_bus.wdata = i_bus.wdata;
        s_bus.sel   = i_bus.sel;
        s_bus.we    = i_bus.we;
        s_bus.cyc   = i_bus.cyc;
        s_bus.stb   = i_bus.stb;
      end
      GNT_DATA: begin
        s_bus.addr  = d_bus.addr;
        s_bus.wdata = d_bus.wdata;
        s_bus.sel   = d_bus.sel;
        s_bus.we    = d_bus.we;
        s_bus.cyc   = d_bus.cyc;
        s_bus.stb   = d_bus.stb;
      end
      default: begin
        s_bus.addr  = {AW{1'b0}};
        s_bus.wdata = {DW{1'b0}};
        s_bus.sel   = {SELW{1'b0}};
        s_bus.we    = 1'b0;
        s_bus.cyc   = 1'b0;
        s_bus.stb   = 1'b0;
      end
    endcase
  end

  // Ack goes only to the owner; read data is broadcast and qualified by ack.
  assign i_bus.ack   = s_bus.ack & (gnt_q == GNT_INST);
  assign d_bus.ack   = s_bus.ack & (gnt_q == GNT_DATA);
  assign i_bus.rdata = s_bus.rdata;
  assign d_bus.rdata = s_bus.rdata;

endmodule
